egress_arbiter: RTL and testbench

Packet-aware round-robin arbiter sharing the egress buffer's single write path among NUM_PORTS requesters (ingress/crossbar lanes). It accepts beats over valid/ready, locks the grant for a full packet (no interleaving), and drives one registered output stream into the egress buffer stage. It is the sequencing and sharing controller in front of the egress datapath.

---
 rtl/egress_pkg.sv | 8 +
 rtl/egress_rr_pick.sv | 24 ++
 rtl/egress_arbiter.sv | 73 +++++++
 tb/tb_egress_arbiter.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/egress_pkg.sv
// egress_pkg: shared types and sizing helpers for the egress arbiter.
package egress_pkg;
  typedef enum logic {ST_IDLE, ST_LOCKED} state_t;
  localparam int NUM_PORTS_DEF = 4;
  function automatic int port_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/egress_rr_pick.sv
// egress_rr_pick: combinational rotating-priority picker, first set request at or after ptr.
module egress_rr_pick
  import egress_pkg::*;
#(
  parameter int N  = NUM_PORTS_DEF,
  parameter int PW = port_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic          any,
  output logic [PW-1:0] winner
);
  function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    return PW'(s >= N ? s - N : s);
  endfunction
  always_comb begin
    any = |req;
    winner = '0;
    for (int k = N - 1; k >= 0; k--)
      if (req[wrap_add(ptr, k)]) winner = wrap_add(ptr, k);
  end
endmodule

// File: rtl/egress_arbiter.sv
// egress_arbiter: packet-locked round-robin arbiter feeding one registered egress stream.
module egress_arbiter
  import egress_pkg::*;
#(
  parameter int WIDTH     = 128,
  parameter int NUM_PORTS = NUM_PORTS_DEF,
  localparam int PW       = port_w(NUM_PORTS)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_PORTS-1:0]       req_valid,
  input  logic [NUM_PORTS*WIDTH-1:0] req_data,
  input  logic [NUM_PORTS-1:0]       req_last,
  output logic [NUM_PORTS-1:0]       req_ready,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_last,
  output logic [PW-1:0]              out_port,
  input  logic                       out_ready,
  output logic                       busy
);
  state_t state, state_nx;
  logic [PW-1:0] owner, owner_nx, rr_ptr, rr_nx, winner, gnt;
  logic any, slot_free, xfer;
  function automatic logic [PW-1:0] next_port(input logic [PW-1:0] p);
    return p == PW'(NUM_PORTS - 1) ? '0 : p + 1'b1;
  endfunction
  egress_rr_pick #(.N(NUM_PORTS), .PW(PW)) u_pick (
    .req(req_valid),
    .ptr(rr_ptr),
    .any(any),
    .winner(winner)
  );
  always_comb begin
    slot_free = !out_valid || out_ready;
    gnt = state == ST_LOCKED ? owner : winner;
    req_ready = '0;
    if (!reset && slot_free && (state == ST_LOCKED || any)) req_ready[gnt] = 1'b1;
    xfer = req_valid[gnt] && req_ready[gnt];
    state_nx = state;
    owner_nx = owner;
    rr_nx = rr_ptr;
    if (xfer) begin
      state_nx = req_last[gnt] ? ST_IDLE : ST_LOCKED;
      owner_nx = gnt;
      rr_nx = req_last[gnt] ? next_port(gnt) : rr_ptr;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      owner <= '0;
      rr_ptr <= '0;
      out_valid <= 1'b0;
      out_data <= '0;
      out_last <= 1'b0;
      out_port <= '0;
    end else begin
      state <= state_nx;
      owner <= owner_nx;
      rr_ptr <= rr_nx;
      if (xfer) begin
        out_valid <= 1'b1;
        out_data <= req_data[int'(gnt)*WIDTH +: WIDTH];
        out_last <= req_last[gnt];
        out_port <= gnt;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
  assign busy = state == ST_LOCKED;
endmodule

// File: tb/tb_egress_arbiter.sv
// tb_egress_arbiter: directed and randomized checks against a packet-level arbiter model.
module tb_egress_arbiter;
  localparam int W = 128, N = 4;
  logic clk = 0, reset, out_valid, out_last, out_ready, busy;
  logic [N-1:0] req_valid, req_last, req_ready;
  logic [N*W-1:0] req_data;
  logic [W-1:0] out_data;
  logic [1:0] out_port;
  int total = 0, bad = 0;
  bit m_locked, m_ov, m_last;
  int m_owner, m_rr, m_port, m_acc;
  logic [W-1:0] m_data;
  always #5 clk = ~clk;
  egress_arbiter #(.WIDTH(W), .NUM_PORTS(N)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .out_valid(out_valid),
    .out_data(out_data), .out_last(out_last), .out_port(out_port),
    .out_ready(out_ready), .busy(busy)
  );
  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [N-1:0] exp_ready();
    logic [N-1:0] one = 1;
    if (reset || !(!m_ov || out_ready)) return '0;
    if (m_locked) return one << m_owner;
    for (int k = 0; k < N; k++)
      if (req_valid[(m_rr + k) % N]) return one << ((m_rr + k) % N);
    return '0;
  endfunction
  task automatic set_port(input int p, input bit v, input bit l, input logic [W-1:0] d);
    req_valid[p] = v;
    req_last[p] = l;
    req_data[p*W +: W] = d;
  endtask
  task automatic step();
    logic [N-1:0] er;
    logic [W-1:0] d;
    int g;
    bit l, rst_now, ordy;
    #1;
    er = exp_ready();
    chk("ready", W'(req_ready), W'(er));
    g = -1;
    for (int p = 0; p < N; p++) if (er[p] && req_valid[p]) g = p;
    d = '0;
    l = 0;
    if (g >= 0) begin
      d = req_data[g*W +: W];
      l = req_last[g];
    end
    rst_now = reset;
    ordy = out_ready;
    @(posedge clk);
    #1;
    m_acc = rst_now ? -1 : g;
    if (rst_now) begin
      m_locked = 0; m_ov = 0; m_last = 0; m_owner = 0; m_rr = 0; m_port = 0; m_data = '0;
    end else if (g >= 0) begin
      m_ov = 1; m_data = d; m_last = l; m_port = g;
      if (l) begin
        m_locked = 0;
        m_rr = (g + 1) % N;
      end else begin
        m_locked = 1;
        m_owner = g;
      end
    end else if (ordy) begin
      m_ov = 0;
    end
    chk("out_valid", W'(out_valid), W'(m_ov));
    chk("busy", W'(busy), W'(m_locked));
    if (m_ov) begin
      chk("out_data", out_data, m_data);
      chk("out_last", W'(out_last), W'(m_last));
      chk("out_port", W'(out_port), W'(m_port));
    end
  endtask
  initial begin
    int len[N], beat[N];
    int ser;
    reset = 1; out_ready = 1; req_valid = '1; req_last = '1; req_data = '0;
    m_locked = 0; m_ov = 0; m_last = 0; m_owner = 0; m_rr = 0; m_port = 0; m_data = '0; m_acc = -1;
    step();
    step();
    chk("rst_data", out_data, '0);
    chk("rst_port", W'(out_port), '0);
    chk("rst_last", W'(out_last), '0);
    reset = 0; req_valid = '0;
    step();
    for (int p = 0; p < N; p++) set_port(p, 1, 1, W'(8'h10 + p));
    for (int i = 0; i < 8; i++) begin
      step();
      chk("rr_port", W'(out_port), W'(i % N));
      chk("rr_valid", W'(out_valid), 1);
    end
    req_valid = '0;
    set_port(1, 1, 0, 'hA1);
    set_port(2, 1, 1, 'hB0);
    step(); chk("lock_a1", out_data, 'hA1);
    set_port(1, 1, 0, 'hA2);
    step(); chk("lock_a2", out_data, 'hA2);
    set_port(1, 1, 1, 'hA3);
    step(); chk("lock_a3", out_data, 'hA3);
    set_port(1, 0, 0, 0);
    step(); chk("after_b0", out_data, 'hB0); chk("after_b0_port", W'(out_port), 2);
    req_valid = '0;
    set_port(1, 1, 0, 'hC1);
    step(); chk("drop_c1", out_data, 'hC1);
    set_port(1, 0, 0, 0);
    set_port(0, 1, 1, 'hD0);
    step(); chk("bubble1", W'(out_valid), 0);
    step(); chk("bubble2", W'(out_valid), 0);
    set_port(1, 1, 1, 'hC2);
    step(); chk("drop_c2", out_data, 'hC2);
    set_port(1, 0, 0, 0);
    step(); chk("drop_d0", out_data, 'hD0); chk("drop_d0_port", W'(out_port), 0);
    req_valid = '0;
    set_port(3, 1, 1, 'h55);
    step(); chk("hold_load", out_data, 'h55);
    set_port(3, 0, 0, 0);
    set_port(0, 1, 1, 'h66);
    out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hold_data", out_data, 'h55);
    end
    out_ready = 1;
    step(); chk("hold_next", out_data, 'h66);
    req_valid = '0;
    step(); chk("hold_drain", W'(out_valid), 0);
    set_port(3, 1, 1, 'h77);
    step(); chk("wrap_p3", W'(out_port), 3);
    set_port(3, 1, 1, 'h78);
    set_port(0, 1, 1, 'h80);
    step(); chk("wrap_p0", W'(out_port), 0);
    set_port(0, 0, 0, 0);
    step(); chk("wrap_next_p3", out_data, 'h78);
    req_valid = '0;
    set_port(2, 1, 0, 'hE1);
    step();
    reset = 1;
    step(); chk("mid_rst_busy", W'(busy), 0); chk("mid_rst_data", out_data, '0);
    reset = 0; req_valid = '0;
    step();
    ser = 0;
    for (int p = 0; p < N; p++) begin
      len[p] = $urandom_range(1, 4);
      beat[p] = 0;
    end
    for (int c = 0; c < 3000; c++) begin
      for (int p = 0; p < N; p++)
        set_port(p, $urandom_range(0, 3) != 0, beat[p] == len[p] - 1, (W'(p) << 64) | W'(ser + p));
      out_ready = $urandom_range(0, 3) != 0;
      reset = $urandom_range(0, 299) == 0;
      step();
      if (m_acc >= 0) begin
        beat[m_acc]++;
        if (beat[m_acc] == len[m_acc]) begin
          beat[m_acc] = 0;
          len[m_acc] = $urandom_range(1, 4);
        end
      end
      ser += 16;
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
